// File: rtl/coffee_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coffee_pkg                                                       |
// | Shared source indices and arbiter state encoding for the         |
// | coffee maker display path.                                       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package coffee_pkg;

  localparam int N_SRC    = 3;
  localparam int SRC_ERR  = 0;
  localparam int SRC_BREW = 1;
  localparam int SRC_MENU = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/display_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_arbiter_if                                               |
// | Request/value bundle from the control logic and the arbitrated   |
// | display value toward seven_segment.                              |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface display_arbiter_if;
  import coffee_pkg::*;

  logic [N_SRC-1:0] req;
  logic [3:0]       val0;
  logic [3:0]       val1;
  logic [3:0]       val2;
  logic [N_SRC-1:0] gnt;
  logic [3:0]       disp_val;
  logic             disp_blank;

  // Control side: raises requests and supplies values
  modport master (
    output req, val0, val1, val2,
    input  gnt, disp_val, disp_blank
  );

  // Arbiter side
  modport slave (
    input  req, val0, val1, val2,
    output gnt, disp_val, disp_blank
  );

endinterface
`default_nettype wire

// File: rtl/display_arbiter_hold_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hold_timer                                                       |
// | Loadable down counter that saturates at zero; expired is high    |
// | while the count is zero.                                         |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module hold_timer #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Reload on a new grant, otherwise count down and stop at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_arbiter                                                  |
// | Fixed-priority arbiter (error > brew > menu) for the shared       |
// | seven-segment display, with a minimum hold on non-error grants.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module display_arbiter
  import coffee_pkg::*;
#(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES)
) (
  input  logic                clk,
  input  logic                rst,
  display_arbiter_if.slave    bus
);

  arb_state_t       state;
  arb_state_t       nxt_state;
  logic [N_SRC-1:0] cur_gnt;
  logic [N_SRC-1:0] nxt_gnt;
  logic [3:0]       cur_val;
  logic [3:0]       nxt_val;
  logic             cur_blank;
  logic             load;
  logic             expired;
  logic [N_SRC-1:0] lowest;
  logic             held;
  logic             lower_pending;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .expired (expired)
  );

  // Priority encoder: isolate the lowest set request bit
  assign lowest = bus.req & (~bus.req + 3'd1);
  assign held   = |(bus.req & cur_gnt);
  // For a one-hot grant, gnt-1 masks every index below it
  assign lower_pending = |(bus.req & (cur_gnt - 3'd1));

  // Next-grant arbitration; any change of grant reloads the hold timer
  always_comb begin
    nxt_state = state;
    nxt_gnt   = cur_gnt;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|bus.req) begin
          nxt_gnt   = lowest;
          nxt_state = ST_HOLD;
          load      = 1'b1;
        end
      end
      ST_HOLD, ST_OPEN: begin
        if (!held) begin
          // Release: hand straight over to the next pending source
          if (|bus.req) begin
            nxt_gnt   = lowest;
            nxt_state = ST_HOLD;
            load      = 1'b1;
          end else begin
            nxt_gnt   = '0;
            nxt_state = ST_IDLE;
          end
        end else if (bus.req[SRC_ERR] && !cur_gnt[SRC_ERR]) begin
          // Errors ignore the hold timer
          nxt_gnt   = 3'b001;
          nxt_state = ST_HOLD;
          load      = 1'b1;
        end else if (state == ST_OPEN || expired) begin
          // Hold done: the edge where the count is zero already acts as OPEN
          if (lower_pending) begin
            nxt_gnt   = lowest;
            nxt_state = ST_HOLD;
            load      = 1'b1;
          end else begin
            nxt_state = ST_OPEN;
          end
        end
      end
      default: begin
        nxt_gnt   = '0;
        nxt_state = ST_IDLE;
      end
    endcase
  end

  // Value mux driven by the next grant so grant and value move together
  always_comb begin
    nxt_val = 4'd0;
    if (nxt_gnt[SRC_ERR])       nxt_val = bus.val0;
    else if (nxt_gnt[SRC_BREW]) nxt_val = bus.val1;
    else if (nxt_gnt[SRC_MENU]) nxt_val = bus.val2;
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_gnt   <= '0;
      cur_val   <= 4'd0;
      cur_blank <= 1'b1;
    end else begin
      state     <= nxt_state;
      cur_gnt   <= nxt_gnt;
      cur_val   <= nxt_val;
      cur_blank <= (nxt_gnt == '0);
    end
  end

  assign bus.gnt        = cur_gnt;
  assign bus.disp_val   = cur_val;
  assign bus.disp_blank = cur_blank;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_display_arbiter                                               |
// | Directed self-checking bench for display_arbiter, HOLD_CYCLES=4. |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_display_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] obs;
  logic [7:0] exp_v;

  display_arbiter_if bus ();

  display_arbiter #(
    .HOLD_CYCLES (4),
    .CNT_W       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Snapshot of {gnt, disp_val, disp_blank}
  function automatic logic [7:0] pack(input logic [2:0] g, input logic [3:0] v, input logic b);
    return {g, v, b};
  endfunction

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 3'b000; bus.val0 = 4'd0; bus.val1 = 4'd0; bus.val2 = 4'd0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b000, 4'd0, 1'b1); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_idle cycle %0d got=%b exp=%b", i, obs, exp_v); end
    end
  endtask

  task automatic test_grant();
    bus.req = 3'b100; bus.val2 = 4'd7;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b100, 4'd7, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL grant_menu got=%b exp=%b", obs, exp_v); end
    bus.val2 = 4'd12;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b100, 4'd12, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL val_track got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b000;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b000, 4'd0, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL grant_release_idle got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_hold();
    bus.req = 3'b100; bus.val2 = 4'd3;
    step();  // grant edge N
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b100, 4'd3, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hold_grant got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b110; bus.val1 = 4'd5;
    for (int k = 1; k <= 3; k++) begin
      step();  // edges N+1..N+3: brew must wait
      obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b100, 4'd3, 1'b0); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL hold_keep edge N+%0d got=%b exp=%b", k, obs, exp_v); end
    end
    step();  // edge N+4: hold expired, brew takes over
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b010, 4'd5, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hold_preempt got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b000;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b000, 4'd0, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hold_idle got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_error_preempt();
    bus.req = 3'b010; bus.val1 = 4'd9;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b010, 4'd9, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL err_pre_grant got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b011; bus.val0 = 4'd14;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b001, 4'd14, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL err_preempt got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b000;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b000, 4'd0, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL err_idle got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_release();
    bus.req = 3'b010; bus.val1 = 4'd6; bus.val2 = 4'd2;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b010, 4'd6, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rel_grant got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b110;
    step();  // menu is a higher index: ignored
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b010, 4'd6, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rel_no_preempt got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b100;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b100, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rel_handover got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b000;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b000, 4'd0, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rel_idle got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_open_no_preempt();
    bus.req = 3'b010; bus.val1 = 4'd1; bus.val2 = 4'd8;
    for (int k = 0; k < 6; k++) step();  // well into OPEN
    bus.req = 3'b110;
    for (int k = 0; k < 3; k++) begin
      step();
      obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b010, 4'd1, 1'b0); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL open_higher_waits k=%0d got=%b exp=%b", k, obs, exp_v); end
    end
    bus.req = 3'b100;  // release and new request on the same edge
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b100, 4'd8, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL open_handover got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_async_reset();
    bus.req = 3'b100; bus.val2 = 4'd9;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b100, 4'd9, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ar_grant got=%b exp=%b", obs, exp_v); end
    #2 rst = 1'b1;
    #1;  // still before the next rising edge
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b000, 4'd0, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ar_async got=%b exp=%b", obs, exp_v); end
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b000, 4'd0, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ar_held got=%b exp=%b", obs, exp_v); end
    #2 rst = 1'b0;
    step();  // first edge after reset falls grants again
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b100, 4'd9, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ar_regrant got=%b exp=%b", obs, exp_v); end
    bus.req = 3'b000;
    step();
    bus.req = 3'b010; bus.val1 = 4'd4;
    step();
    obs = {bus.gnt, bus.disp_val, bus.disp_blank}; exp_v = pack(3'b010, 4'd4, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ar_rearb got=%b exp=%b", obs, exp_v); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_grant();
    test_hold();
    test_error_preempt();
    test_release();
    test_open_no_preempt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
